cnn_layer_scheduler: RTL

Multi-layer job sequencer sitting in front of the CNN convolution controller. Holds a small host-written table of layer descriptors and, on `start`, drives the controller's shape inputs, output-memory base address and enable layer by layer. It waits for the controller's end-of-layer pulse, then advances to the next layer. It reports job completion, configuration errors and run-cycle count back to the host.

---
 rtl/cnn_layer_scheduler.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/cnn_layer_scheduler.sv
// rtl/cnn_layer_scheduler.sv - multi-layer job sequencer for the CNN convolution controller
//
// Holds a host-written table of layer descriptors and, on start, walks the
// controller through the layers one at a time.
//
// Ports:
//   clk_i, reset_ni            clock (rising edge), asynchronous active-low reset
//   cfg_we_i, cfg_idx_i, cfg_* descriptor table write port (accepted only in IDLE)
//   num_layers_i, start_i      job length and start pulse
//   abort_i                    abandon the current job
//   layer_done_i               end-of-layer pulse from the controller
//   num_filter_o .. out_base_o registered layer shape and output base address
//   ctrl_enable_o, ctrl_clear_o controller enable and one-cycle counter clear
//   layer_idx_o, busy_o, done_o, err_o, run_cycles_o  job status to the host
module cnn_layer_scheduler #(
  parameter int FILTERNUM_WIDTH = 8,
  parameter int KERNELNUM_WIDTH = 8,
  parameter int DATANUM_WIDTH   = 8,
  parameter int TIMESTEP_WIDTH  = 8,
  parameter int ADDR_WIDTH      = 10,
  parameter int MAX_LAYERS      = 4,
  parameter int LAYER_IDX_WIDTH = $clog2(MAX_LAYERS),
  parameter int SETTLE_CYCLES   = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       cfg_we_i,
  input  logic [LAYER_IDX_WIDTH-1:0] cfg_idx_i,
  input  logic [FILTERNUM_WIDTH-1:0] cfg_num_filter_i,
  input  logic [KERNELNUM_WIDTH-1:0] cfg_num_kernel_i,
  input  logic [DATANUM_WIDTH-1:0]   cfg_filter_length_i,
  input  logic [TIMESTEP_WIDTH-1:0]  cfg_num_total_conv_i,
  input  logic [ADDR_WIDTH-1:0]      cfg_out_base_i,
  input  logic [LAYER_IDX_WIDTH:0]   num_layers_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic                       layer_done_i,
  output logic [FILTERNUM_WIDTH-1:0] num_filter_o,
  output logic [KERNELNUM_WIDTH-1:0] num_kernel_o,
  output logic [DATANUM_WIDTH-1:0]   filter_length_o,
  output logic [TIMESTEP_WIDTH-1:0]  num_total_conv_o,
  output logic [ADDR_WIDTH-1:0]      out_base_o,
  output logic                       ctrl_enable_o,
  output logic                       ctrl_clear_o,
  output logic [LAYER_IDX_WIDTH-1:0] layer_idx_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [CNT_WIDTH-1:0]       run_cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_NEXT, S_DONE
  } state_e;

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0]      SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [LAYER_IDX_WIDTH:0] NL_MAX      = (LAYER_IDX_WIDTH + 1)'(MAX_LAYERS);
  localparam logic [LAYER_IDX_WIDTH:0] NL_ONE      = (LAYER_IDX_WIDTH + 1)'(1);

  state_e state_q, state_d;

  logic [FILTERNUM_WIDTH-1:0] tbl_filter_q [MAX_LAYERS];
  logic [KERNELNUM_WIDTH-1:0] tbl_kernel_q [MAX_LAYERS];
  logic [DATANUM_WIDTH-1:0]   tbl_length_q [MAX_LAYERS];
  logic [TIMESTEP_WIDTH-1:0]  tbl_conv_q   [MAX_LAYERS];
  logic [ADDR_WIDTH-1:0]      tbl_base_q   [MAX_LAYERS];

  logic [LAYER_IDX_WIDTH:0]   num_layers_q;
  logic [LAYER_IDX_WIDTH-1:0] layer_idx_q;
  logic [SETTLE_W-1:0]        settle_cnt_q;
  logic                       abort_clr_q;
  logic                       err_q;
  logic [CNT_WIDTH-1:0]       run_cycles_q;
  logic [FILTERNUM_WIDTH-1:0] num_filter_q;
  logic [KERNELNUM_WIDTH-1:0] num_kernel_q;
  logic [DATANUM_WIDTH-1:0]   filter_length_q;
  logic [TIMESTEP_WIDTH-1:0]  num_total_conv_q;
  logic [ADDR_WIDTH-1:0]      out_base_q;

  logic start_ok, desc_zero, last_layer, aborting;

  assign start_ok   = (num_layers_i != '0) && (num_layers_i <= NL_MAX);
  // out_base of 0 is a legal address, so it is not part of the validity check.
  assign desc_zero  = (tbl_filter_q[layer_idx_q] == '0) || (tbl_kernel_q[layer_idx_q] == '0) ||
                      (tbl_length_q[layer_idx_q] == '0) || (tbl_conv_q[layer_idx_q] == '0);
  assign last_layer = ({1'b0, layer_idx_q} == (num_layers_q - NL_ONE));
  assign aborting   = abort_i && (state_q != S_IDLE);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    busy_o        = 1'b0;
    ctrl_enable_o = 1'b0;
    done_o        = 1'b0;
    ctrl_clear_o  = abort_clr_q;
    case (state_q)
      S_IDLE:   if (start_i && start_ok) state_d = S_LOAD;
      S_LOAD: begin
        busy_o       = 1'b1;
        ctrl_clear_o = 1'b1;
        state_d      = desc_zero ? S_DONE : S_SETTLE;
      end
      S_SETTLE: begin
        busy_o = 1'b1;
        if (settle_cnt_q == SETTLE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        busy_o        = 1'b1;
        ctrl_enable_o = 1'b1;
        if (layer_done_i) state_d = S_NEXT;
      end
      S_NEXT: begin
        busy_o  = 1'b1;
        state_d = last_layer ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
    // Abort overrides every transition, including a same-cycle layer_done.
    if (aborting) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        tbl_filter_q[i] <= '0;
        tbl_kernel_q[i] <= '0;
        tbl_length_q[i] <= '0;
        tbl_conv_q[i]   <= '0;
        tbl_base_q[i]   <= '0;
      end
      num_layers_q     <= '0;
      layer_idx_q      <= '0;
      settle_cnt_q     <= '0;
      abort_clr_q      <= 1'b0;
      err_q            <= 1'b0;
      run_cycles_q     <= '0;
      num_filter_q     <= '0;
      num_kernel_q     <= '0;
      filter_length_q  <= '0;
      num_total_conv_q <= '0;
      out_base_q       <= '0;
    end else begin
      abort_clr_q <= aborting;
      case (state_q)
        S_IDLE: begin
          // The write lands in the same edge as start, so the first LOAD sees it.
          if (cfg_we_i) begin
            tbl_filter_q[cfg_idx_i] <= cfg_num_filter_i;
            tbl_kernel_q[cfg_idx_i] <= cfg_num_kernel_i;
            tbl_length_q[cfg_idx_i] <= cfg_filter_length_i;
            tbl_conv_q[cfg_idx_i]   <= cfg_num_total_conv_i;
            tbl_base_q[cfg_idx_i]   <= cfg_out_base_i;
          end
          if (start_i) begin
            if (start_ok) begin
              err_q        <= 1'b0;
              run_cycles_q <= '0;
              num_layers_q <= num_layers_i;
              layer_idx_q  <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          settle_cnt_q <= '0;
          if (!abort_i) begin
            if (desc_zero) begin
              err_q <= 1'b1;
            end else begin
              num_filter_q     <= tbl_filter_q[layer_idx_q];
              num_kernel_q     <= tbl_kernel_q[layer_idx_q];
              filter_length_q  <= tbl_length_q[layer_idx_q];
              num_total_conv_q <= tbl_conv_q[layer_idx_q];
              out_base_q       <= tbl_base_q[layer_idx_q];
            end
          end
        end
        S_SETTLE: settle_cnt_q <= settle_cnt_q + SETTLE_W'(1);
        S_RUN: begin
          if (!abort_i && (run_cycles_q != '1)) run_cycles_q <= run_cycles_q + CNT_WIDTH'(1);
        end
        S_NEXT: begin
          if (!abort_i && !last_layer) layer_idx_q <= layer_idx_q + LAYER_IDX_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign num_filter_o     = num_filter_q;
  assign num_kernel_o     = num_kernel_q;
  assign filter_length_o  = filter_length_q;
  assign num_total_conv_o = num_total_conv_q;
  assign out_base_o       = out_base_q;
  assign layer_idx_o      = layer_idx_q;
  assign err_o            = err_q;
  assign run_cycles_o     = run_cycles_q;

endmodule
